// File: rtl/flap_pkg.sv
// flap_pkg: shared FSM state encoding and flap counter width for flap_input.
// Rev 1.0
`default_nettype none

package flap_pkg;

  typedef enum logic [1:0] {
    S_READY    = 2'd0,
    S_ARMED    = 2'd1,
    S_COOL     = 2'd2,
    S_WAIT_REL = 2'd3
  } flap_state_e;

  localparam int unsigned FLAP_CNT_W = 16;

endpackage

`default_nettype wire

// File: rtl/btn_debounce.sv
// btn_debounce: 2-FF synchroniser plus ms-based debouncer for the raw flap button.
// Rev 1.0
`default_nettype none

module btn_debounce #(
  parameter int unsigned DEBOUNCE_MS = 10,
  parameter int unsigned CNT_W       = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  input  logic ms_tick,
  output logic btn_level
);

  localparam logic [CNT_W-1:0] C_DEB_LAST = CNT_W'(DEBOUNCE_MS - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             lvl_q;
  logic [CNT_W-1:0] deb_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      lvl_q     <= 1'b0;
      deb_cnt_q <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      // Any clk where the synchronised input agrees with the level restarts the run.
      if (sync2_q == lvl_q) begin
        deb_cnt_q <= '0;
      end else if (ms_tick) begin
        if (deb_cnt_q == C_DEB_LAST) begin
          lvl_q     <= sync2_q;
          deb_cnt_q <= '0;
        end else begin
          deb_cnt_q <= deb_cnt_q + CNT_W'(1);
        end
      end
    end
  end

  assign btn_level = lvl_q;

endmodule

`default_nettype wire

// File: rtl/flap_input.sv
// flap_input: debounced button to one tick-aligned, cooldown-limited flap strobe.
// Optional auto-repeat while held: define FLAP_AUTO_REPEAT_EN. Rev 1.0
`default_nettype none

module flap_input
  import flap_pkg::*;
#(
  parameter int unsigned DEBOUNCE_MS = 10,
  parameter int unsigned COOLDOWN_MS = 80,
  parameter int unsigned REPEAT_MS   = 200,
  parameter int unsigned CNT_W       = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  btn_raw,
  input  logic                  ms_tick,
  input  logic                  game_active,
  output logic                  up_button,
  output logic                  btn_level,
  output logic [FLAP_CNT_W-1:0] flap_count
);

  localparam int unsigned C_MS_MAX =
    (DEBOUNCE_MS > COOLDOWN_MS) ?
      ((DEBOUNCE_MS > REPEAT_MS) ? DEBOUNCE_MS : REPEAT_MS) :
      ((COOLDOWN_MS > REPEAT_MS) ? COOLDOWN_MS : REPEAT_MS);

  localparam logic [CNT_W-1:0] C_COOL_LAST = CNT_W'(COOLDOWN_MS - 1);

  if (64'(C_MS_MAX) > (64'd1 << CNT_W)) begin : g_cnt_w_check
    $error("flap_input: CNT_W too narrow for the ms parameters");
  end

  flap_state_e           state_q, state_d;
  logic [CNT_W-1:0]      cool_q, cool_d;
  logic [FLAP_CNT_W-1:0] flap_count_q;
  logic                  lvl_prev_q;
  logic                  fire;

`ifdef FLAP_AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] C_REP_LAST = CNT_W'(REPEAT_MS - 1);
  logic [CNT_W-1:0] rep_q, rep_d;
`endif

  btn_debounce #(
    .DEBOUNCE_MS (DEBOUNCE_MS),
    .CNT_W       (CNT_W)
  ) u_debounce (
    .clk       (clk),
    .rst       (rst),
    .btn_raw   (btn_raw),
    .ms_tick   (ms_tick),
    .btn_level (btn_level)
  );

  always_comb begin
    state_d = state_q;
    cool_d  = cool_q;
    fire    = 1'b0;
`ifdef FLAP_AUTO_REPEAT_EN
    rep_d   = rep_q;
`endif
    case (state_q)
      S_READY: begin
        if (btn_level && !lvl_prev_q) state_d = S_ARMED;
      end
      S_ARMED: begin
        if (ms_tick) begin
          if (game_active) fire = 1'b1;
          else             state_d = S_READY;
        end
      end
      S_COOL: begin
        if (ms_tick) begin
          if (cool_q == '0) begin
            state_d = btn_level ? S_WAIT_REL : S_READY;
`ifdef FLAP_AUTO_REPEAT_EN
            rep_d   = '0;
`endif
          end else begin
            cool_d = cool_q - CNT_W'(1);
          end
        end
      end
      S_WAIT_REL: begin
        if (!btn_level) begin
          state_d = S_READY;
`ifdef FLAP_AUTO_REPEAT_EN
        end else if (ms_tick) begin
          // A repeat tick with play paused restarts the interval instead of queueing.
          if (rep_q == C_REP_LAST) begin
            if (game_active) fire = 1'b1;
            else             rep_d = '0;
          end else begin
            rep_d = rep_q + CNT_W'(1);
          end
`endif
        end
      end
      default: state_d = S_READY;
    endcase
    if (fire) begin
      state_d = S_COOL;
      cool_d  = C_COOL_LAST;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_READY;
      cool_q       <= '0;
      flap_count_q <= '0;
      lvl_prev_q   <= 1'b0;
`ifdef FLAP_AUTO_REPEAT_EN
      rep_q        <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cool_q     <= cool_d;
      lvl_prev_q <= btn_level;
`ifdef FLAP_AUTO_REPEAT_EN
      rep_q      <= rep_d;
`endif
      if (fire) flap_count_q <= flap_count_q + 16'd1;
    end
  end

  // Strobe is combinational so it lands on the ms_tick clk itself; reset masks it.
  assign up_button  = fire && !rst;
  assign flap_count = flap_count_q;

endmodule

`default_nettype wire
